// File: rtl/mant_mult_seq.sv
// Sequential shift-and-add significand multiplier.
// Runs one partial product per cycle, so a non-zero multiply takes SIG_W cycles.
module mant_mult_seq #(
  parameter int unsigned SIG_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIG_W-1:0]     a_sig,
  input  logic [SIG_W-1:0]     b_sig,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*SIG_W-1:0]   product
);

  localparam int unsigned ProdW = 2 * SIG_W;
  localparam int unsigned CntW  = $clog2(SIG_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SIG_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [ProdW-1:0]  acc_q, acc_d;
  logic [ProdW-1:0]  mcand_q, mcand_d;
  logic [SIG_W-1:0]  mplr_q, mplr_d;
  logic [CntW-1:0]   count_q, count_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    count_d   = count_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d = '0;
          // A zero operand makes the product trivially zero; skip the iterations.
          if (a_sig != '0 && b_sig != '0) begin
            mcand_d = ProdW'(a_sig);
            mplr_d  = b_sig;
            count_d = '0;
            state_d = StCalc;
          end else begin
            state_d = StDone;
          end
        end
      end
      StCalc: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + CntW'(1);
        if (count_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      count_q <= count_d;
    end
  end

  assign product = acc_q;

endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: directed vector table, stall/reset corner
// sequences, then a randomised handshake run checked against a reference multiply.
module tb_mant_mult_seq;

  localparam int unsigned SigW = 24;
  localparam int unsigned PW   = 2 * SigW;
  localparam int unsigned NRnd = 400;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SigW-1:0] a_sig;
  logic [SigW-1:0] b_sig;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   product;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic [SigW-1:0] a;
    logic [SigW-1:0] b;
    logic [PW-1:0]   p;
  } vec_t;

  always #5 clk = ~clk;

  mant_mult_seq #(.SIG_W(SigW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sig     (a_sig),
    .b_sig     (b_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [SigW-1:0] a, input logic [SigW-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  function automatic logic [SigW-1:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return {SigW{1'b1}};
    return SigW'($urandom);
  endfunction

  // One operation with out_ready high; checks latency, product and back-to-back ready.
  task automatic run_op(input logic [SigW-1:0] a, input logic [SigW-1:0] b,
                        input logic [PW-1:0] want, input string name);
    int lat;
    logic [PW-1:0] e;
    a_sig = a; b_sig = b; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    while (!in_ready && lat < 100) begin step(); lat++; end
    check({name, " ready_before"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    exp_q.push_back(ref_mul(a, b));
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({name, " busy_ready"}, 64'(in_ready), 64'(0));
      step();
      lat++;
    end
    check({name, " latency"}, 64'(lat), (a == '0 || b == '0) ? 64'(1) : 64'(SigW + 1));
    e = exp_q.pop_front();
    check({name, " model"}, 64'(e), 64'(want));
    check({name, " product"}, 64'(product), 64'(want));
    step();
    check({name, " valid_drop"}, 64'(out_valid), 64'(0));
    check({name, " ready_after"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    vec_t vecs[10];
    logic [PW-1:0] e;
    logic saw_valid;
    int lat;

    vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[2] = '{24'h000000, 24'hC00000, 48'h000000000000};
    vecs[3] = '{24'hC00000, 24'h000000, 48'h000000000000};
    vecs[4] = '{24'h800000, 24'hFFFFFF, 48'h7FFFFF800000};
    vecs[5] = '{24'h000001, 24'h000001, 48'h000000000001};
    vecs[6] = '{24'h000003, 24'h000005, 48'h00000000000F};
    vecs[7] = '{24'h7FFFFF, 24'h000002, 48'h000000FFFFFE};
    vecs[8] = '{24'h400000, 24'h400000, 48'h100000000000};
    vecs[9] = '{24'hC00000, 24'hA00000, 48'h780000000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_sig = '0; b_sig = '0;
    repeat (3) step();
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset product", 64'(product), 64'(0));

    // Reset beats a simultaneous handshake.
    in_valid = 1'b1; a_sig = 24'h800000; b_sig = 24'h800000;
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rst_prio in_ready", 64'(in_ready), 64'(1));
    check("rst_prio out_valid", 64'(out_valid), 64'(0));

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Output stall: product and out_valid hold, new in_valid ignored.
    a_sig = 24'hC00000; b_sig = 24'hA00000; in_valid = 1'b1; out_ready = 1'b0;
    step();
    exp_q.push_back(ref_mul(24'hC00000, 24'hA00000));
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    check("stall latency", 64'(lat), 64'(SigW + 1));
    in_valid = 1'b1; a_sig = 24'h000001; b_sig = 24'h000001;
    for (int i = 0; i < 10; i++) begin
      check("stall product", 64'(product), 64'(48'h780000000000));
      check("stall out_valid", 64'(out_valid), 64'(1));
      check("stall in_ready", 64'(in_ready), 64'(0));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    e = exp_q.pop_front();
    check("stall model", 64'(product), 64'(e));
    step();
    check("stall release valid", 64'(out_valid), 64'(0));
    check("stall release ready", 64'(in_ready), 64'(1));
    check("stall retained", 64'(product), 64'(48'h780000000000));
    step();
    check("stall single hs", 64'(out_valid), 64'(0));

    // Reset on the 10th CALC cycle discards the operation.
    a_sig = 24'h123456; b_sig = 24'h654321; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst in_ready", 64'(in_ready), 64'(1));
    check("midrst out_valid", 64'(out_valid), 64'(0));
    check("midrst product", 64'(product), 64'(0));
    saw_valid = 1'b0;
    repeat (30) begin step(); saw_valid |= out_valid; end
    check("midrst no pulse", 64'(saw_valid), 64'(0));
    run_op(24'h800000, 24'hFFFFFF, 48'h7FFFFF800000, "post_rst");

    // Randomised traffic with input/output stalls.
    begin
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      logic accepted;
      logic prev_stall = 1'b0;
      logic [PW-1:0] prev_prod = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      while (recv < NRnd && cyc < NRnd * 60) begin
        if (prev_stall) begin
          check("rnd hold product", 64'(product), 64'(prev_prod));
          check("rnd hold valid", 64'(out_valid), 64'(1));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("rnd extra result", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rnd product #%0d", recv), 64'(product), 64'(e));
          end
          recv++;
        end
        prev_stall = out_valid && !out_ready;
        prev_prod  = product;
        accepted   = in_valid && in_ready;
        if (accepted) begin
          exp_q.push_back(ref_mul(a_sig, b_sig));
          sent++;
        end
        step();
        cyc++;
        if (accepted) in_valid = 1'b0;
        if (in_valid && !in_ready) begin
          a_sig = rand_op(); b_sig = rand_op();
        end
        if (!in_valid && sent < NRnd && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b1; a_sig = rand_op(); b_sig = rand_op();
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
      check("rnd results", 64'(recv), 64'(NRnd));
      check("rnd queue empty", 64'(exp_q.size()), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
